// File: rtl/joy_serial_reader.sv
// Scans an external 74HC165-style shift-register chain.
// Each completed scan is presented as one parallel, active-high button word.
module joy_serial_reader #(
  parameter int unsigned CLK_DIV   = 64,
  parameter int unsigned NBITS     = 16,
  parameter int unsigned GAP_TICKS = 0,
  parameter int unsigned INVERT    = 1
) (
  input  logic             CLK25,
  input  logic             RESET,
  input  logic             joy_data,
  output logic             joy_clk,
  output logic             joy_load,
  output logic [NBITS-1:0] data_o,
  output logic             valid_o,
  output logic             changed_o
);

  localparam int unsigned PRE_W = $clog2(CLK_DIV);
  localparam int unsigned BIT_W = $clog2(NBITS);
  localparam int unsigned GAP_W = (GAP_TICKS > 0) ? $clog2(GAP_TICKS + 1) : 1;

  typedef enum logic [2:0] {
    IDLE, LOAD, LATCH, CLK_LO, CLK_HI, DONE, GAP
  } state_t;

  state_t             state_q, state_d;
  logic [PRE_W-1:0]   pre_q, pre_d;
  logic [BIT_W-1:0]   bit_q, bit_d;
  logic [GAP_W-1:0]   gap_q, gap_d;
  logic [NBITS-1:0]   shreg_q, shreg_d;
  logic [NBITS-1:0]   data_q, data_d;
  logic               meta_q, meta_d;
  logic               sync_q, sync_d;
  logic               joy_clk_q, joy_clk_d;
  logic               joy_load_q, joy_load_d;
  logic               valid_q, valid_d;
  logic               changed_q, changed_d;
  logic               tick_c;
  logic [NBITS-1:0]   word_c;

  assign tick_c = (pre_q == PRE_W'(CLK_DIV - 1));
  assign word_c = (INVERT != 0) ? ~shreg_q : shreg_q;

  // Next-state, datapath and output decode
  always_comb begin
    state_d    = state_q;
    pre_d      = tick_c ? '0 : pre_q + PRE_W'(1);
    bit_d      = bit_q;
    gap_d      = gap_q;
    shreg_d    = shreg_q;
    data_d     = data_q;
    meta_d     = joy_data;
    sync_d     = meta_q;
    valid_d    = 1'b0;
    changed_d  = 1'b0;

    case (state_q)
      IDLE:   if (tick_c) state_d = LOAD;
      LOAD:   if (tick_c) state_d = LATCH;
      LATCH: begin
        if (tick_c) begin
          bit_d   = '0;
          state_d = CLK_LO;
        end
      end
      CLK_LO: begin
        if (tick_c) begin
          shreg_d = {shreg_q[NBITS-2:0], sync_q};
          state_d = CLK_HI;
        end
      end
      CLK_HI: begin
        if (tick_c) begin
          if (bit_q == BIT_W'(NBITS - 1)) begin
            state_d = DONE;
          end else begin
            bit_d   = bit_q + BIT_W'(1);
            state_d = CLK_LO;
          end
        end
      end
      DONE: begin
        // Restart the prescaler so the following LOAD/GAP gets full ticks
        data_d    = word_c;
        valid_d   = 1'b1;
        changed_d = (word_c != data_q);
        pre_d     = '0;
        gap_d     = '0;
        state_d   = (GAP_TICKS > 0) ? GAP : LOAD;
      end
      GAP: begin
        if (tick_c) begin
          if (gap_q == GAP_W'(GAP_TICKS - 1)) begin
            gap_d   = '0;
            state_d = LOAD;
          end else begin
            gap_d = gap_q + GAP_W'(1);
          end
        end
      end
      default: state_d = IDLE;
    endcase

    joy_load_d = (state_d != LOAD);
    joy_clk_d  = (state_d == CLK_HI);
  end

  always_ff @(posedge CLK25 or posedge RESET) begin
    if (RESET) begin
      state_q    <= IDLE;
      pre_q      <= '0;
      bit_q      <= '0;
      gap_q      <= '0;
      shreg_q    <= '0;
      data_q     <= '0;
      meta_q     <= 1'b0;
      sync_q     <= 1'b0;
      joy_clk_q  <= 1'b0;
      joy_load_q <= 1'b1;
      valid_q    <= 1'b0;
      changed_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      pre_q      <= pre_d;
      bit_q      <= bit_d;
      gap_q      <= gap_d;
      shreg_q    <= shreg_d;
      data_q     <= data_d;
      meta_q     <= meta_d;
      sync_q     <= sync_d;
      joy_clk_q  <= joy_clk_d;
      joy_load_q <= joy_load_d;
      valid_q    <= valid_d;
      changed_q  <= changed_d;
    end
  end

  assign joy_clk   = joy_clk_q;
  assign joy_load  = joy_load_q;
  assign data_o    = data_q;
  assign valid_o   = valid_q;
  assign changed_o = changed_q;

endmodule
